// File: rtl/seg7_pkg.sv
// Shared segment encodings, FSM state type and pattern-to-digit lookup for the scan capture.
// SEG7_HEX_DECODE_EN additionally accepts the A..F glyphs as values 10..15.
package seg7_pkg;

  // Segment order on the bus: bit6=a, bit5=b ... bit0=g.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StLocked
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } seg_dec_t;

  function automatic seg_dec_t seg_to_digit(input logic [6:0] seg);
    seg_dec_t r;
    r.legal = 1'b1;
    r.value = 4'd0;
    case (seg)
      SEG_0:   r.value = 4'd0;
      SEG_1:   r.value = 4'd1;
      SEG_2:   r.value = 4'd2;
      SEG_3:   r.value = 4'd3;
      SEG_4:   r.value = 4'd4;
      SEG_5:   r.value = 4'd5;
      SEG_6:   r.value = 4'd6;
      SEG_7:   r.value = 4'd7;
      SEG_8:   r.value = 4'd8;
      SEG_9:   r.value = 4'd9;
`ifdef SEG7_HEX_DECODE_EN
      SEG_A:   r.value = 4'd10;
      SEG_B:   r.value = 4'd11;
      SEG_C:   r.value = 4'd12;
      SEG_D:   r.value = 4'd13;
      SEG_E:   r.value = 4'd14;
      SEG_F:   r.value = 4'd15;
`endif
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational segment-pattern decoder; legal_o is low for blank and unknown glyphs.
// Hex glyph acceptance follows SEG7_HEX_DECODE_EN through seg7_pkg::seg_to_digit.
module seg7_pattern_decoder (
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic [3:0] value_o
);
  import seg7_pkg::*;

  seg_dec_t dec;

  always_comb begin
    dec     = seg_to_digit(seg_i);
    legal_o = dec.legal;
    value_o = dec.value;
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reader for a scanned 7-segment bus: filters each strobe/segment sample for stability and
// commits the decoded digit per position. SEG7_HEX_DECODE_EN enables A..F decoding.
module seg7_scan_capture #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_err,
  output logic                    frame_done
);
  import seg7_pkg::*;

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0]   s_an_q, p_an_q;
  logic [6:0]              s_seg_q, p_seg_q;
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;

  logic                    strobe_ok;
  logic                    same;
  logic                    commit;
  logic [IdxW-1:0]         pos;
  logic                    dec_legal;
  logic [3:0]              dec_value;

  seg7_pattern_decoder u_dec (
    .seg_i   (s_seg_q),
    .legal_o (dec_legal),
    .value_o (dec_value)
  );

  // Zero or multi-hot strobes are treated as no strobe at all.
  always_comb begin
    strobe_ok = (s_an_q != '0) && ((s_an_q & (s_an_q - NUM_DIGITS'(1))) == '0);
    same      = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);
    pos       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_an_q[i]) pos = IdxW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!strobe_ok) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StTrack;
          cnt_d   = 4'd1;
        end
        StTrack: begin
          if (same) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == 4'(STABLE_CNT)) begin
              commit  = 1'b1;
              state_d = StLocked;
            end
          end else begin
            cnt_d = 4'd1;
          end
        end
        StLocked: begin
          if (!same) begin
            state_d = StTrack;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A commit landing on the frame_done edge starts the next frame's seen mask.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    frame_d  = &seen_q;
    seen_d   = (&seen_q) ? '0 : seen_q;
    if (commit) begin
      seen_d[pos] = 1'b1;
      if (dec_legal) begin
        digits_d[4*pos +: 4] = dec_value;
        valid_d[pos]         = 1'b1;
        err_d[pos]           = 1'b0;
      end else begin
        valid_d[pos] = 1'b0;
        err_d[pos]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_an_q   <= '0;
      s_seg_q  <= '0;
      p_an_q   <= '0;
      p_seg_q  <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      s_an_q   <= an;
      s_seg_q  <= seg;
      p_an_q   <= s_an_q;
      p_seg_q  <= s_seg_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign pattern_err = err_q;
  assign frame_done  = frame_q;

endmodule
